// File: rtl/scan_pkg.sv
// Shared state encoding and sizing helpers for the scan-chain controller.
// S_CAP exists only when SCAN_CAPTURE_EN is defined.
package scan_pkg;
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LOW  = 3'd1;
  localparam state_t S_HIGH = 3'd2;
`ifdef SCAN_CAPTURE_EN
  localparam state_t S_CAP  = 3'd3;
`endif
  localparam state_t S_DONE = 3'd4;

  // A DIV of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int phase_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Request/response side of the scan-chain master (register-interface facing).
// SCAN_CAPTURE_EN adds the capture request bit.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 start;
  logic [CHAIN_LEN-1:0] load_data;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] capture_data;
`ifdef SCAN_CAPTURE_EN
  logic                 capture;

  modport master (output start, load_data, capture, input busy, done, capture_data);
  modport slave  (input start, load_data, capture, output busy, done, capture_data);
`else
  modport master (output start, load_data, input busy, done, capture_data);
  modport slave  (input start, load_data, output busy, done, capture_data);
`endif
endinterface

// File: rtl/scan_clk_gen.sv
// Phase timer for the scan clock: ticks phase_end every DIV enabled cycles and
// loads the registered shift_clk with the FSM's requested level on each tick.
module scan_clk_gen
  import scan_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic rise,
  output logic phase_end,
  output logic shift_clk
);
  localparam int PW = phase_w(DIV);

  logic [PW-1:0] cnt;

  assign phase_end = en && (cnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shift_clk <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (phase_end) begin
      cnt       <= '0;
      shift_clk <= rise;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end
endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain master: shifts load_data into the chain LSB-first while capturing its old contents.
// Define SCAN_CAPTURE_EN to add a functional-capture pulse between two shift passes.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int DIV       = 2
) (
  input  logic             clk,
  input  logic             rst,
  scan_chain_ctrl_if.slave bus,
  output logic             shift_clk,
  output logic             scan_out,
  input  logic             scan_in
`ifdef SCAN_CAPTURE_EN
  ,
  output logic             cap_pulse
`endif
);
  localparam int BW = $clog2(CHAIN_LEN + 1);

  state_t               state;
  logic [CHAIN_LEN-1:0] sreg, cap_sreg, cap_shift;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 accept, run, phase_end, last_bit;

  assign accept      = (state == S_IDLE) && bus.start;
  assign bit_cnt_nxt = bit_cnt + BW'(1);
  assign last_bit    = (bit_cnt_nxt == BW'(CHAIN_LEN));
  // sreg back-fills with zeros, so scan_out is already low in DONE/IDLE
  assign scan_out    = sreg[0];

`ifdef SCAN_CAPTURE_EN
  logic cap_mode;
  assign run = (state == S_LOW) || (state == S_HIGH) || (state == S_CAP);
`else
  assign run = (state == S_LOW) || (state == S_HIGH);
`endif

  always_comb begin
    cap_shift              = cap_sreg >> 1;
    cap_shift[CHAIN_LEN-1] = scan_in;
  end

  scan_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .clr       (accept),
    .rise      (state == S_LOW),
    .phase_end (phase_end),
    .shift_clk (shift_clk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.capture_data <= '0;
      sreg             <= '0;
      cap_sreg         <= '0;
      bit_cnt          <= '0;
`ifdef SCAN_CAPTURE_EN
      cap_mode         <= 1'b0;
      cap_pulse        <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          sreg     <= bus.load_data;
          bit_cnt  <= '0;
          bus.busy <= 1'b1;
          state    <= S_LOW;
`ifdef SCAN_CAPTURE_EN
          cap_mode <= bus.capture;
`endif
        end
        // sample the tail just before shift_clk rises: it still holds the pre-shift bit
        S_LOW: if (phase_end) begin
          cap_sreg <= cap_shift;
          state    <= S_HIGH;
        end
        S_HIGH: if (phase_end) begin
          sreg    <= sreg >> 1;
          bit_cnt <= bit_cnt_nxt;
          if (!last_bit) begin
            state <= S_LOW;
          end
`ifdef SCAN_CAPTURE_EN
          else if (cap_mode) begin
            cap_mode  <= 1'b0;
            bit_cnt   <= '0;
            cap_pulse <= 1'b1;
            state     <= S_CAP;
          end
`endif
          else begin
            state            <= S_DONE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
            bus.capture_data <= cap_sreg;
          end
        end
`ifdef SCAN_CAPTURE_EN
        // first phase clocks the functional flops, second lets them settle before readout
        S_CAP: if (phase_end) begin
          cap_pulse <= 1'b0;
          if (!cap_pulse) state <= S_LOW;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
